// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR sequencer: FSM state encoding,
// default parameter values and the accumulator width helper.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam int ADDRESS_SIZE_DEF = 13;
  localparam int DATA_SIZE_DEF    = 16;
  localparam int COEF_SIZE_DEF    = 16;
  localparam int OUT_SIZE_DEF     = 21;
  localparam int TAPS_DEF         = 32;
  localparam int SHIFT_DEF        = 15;

  // Wide enough to sum TAPS full-scale products without overflow.
  function automatic int acc_width(input int d_size, input int c_size, input int taps);
    return d_size + c_size + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate with arithmetic output scaling.
// Define FIR_SAT_EN to saturate the scaled result; otherwise it wraps.
module fir_mac
  import fir_pkg::*;
#(
  parameter int data_SIZE = DATA_SIZE_DEF,
  parameter int coef_SIZE = COEF_SIZE_DEF,
  parameter int out_SIZE  = OUT_SIZE_DEF,
  parameter int TAPS      = TAPS_DEF,
  parameter int SHIFT     = SHIFT_DEF
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [data_SIZE-1:0] sample,
  input  logic [coef_SIZE-1:0] coef,
  output logic [out_SIZE-1:0]  result
);

  localparam int PROD_W = data_SIZE + coef_SIZE;
  localparam int ACC_W  = acc_width(data_SIZE, coef_SIZE, TAPS);

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  shifted;

  assign product = $signed(sample) * $signed(coef);

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      acc_reg <= '0;
    end else if (enable) begin
      acc_reg <= acc_reg + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    end
  end

  assign shifted = acc_reg >>> SHIFT;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-out_SIZE+1){1'b0}}, {(out_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-out_SIZE+1){1'b1}}, {(out_SIZE-1){1'b0}}};

  always_comb begin
    result = shifted[out_SIZE-1:0];
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[out_SIZE-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[out_SIZE-1:0];
    end
  end
`else
  logic unused_high;

  // Plain two's-complement wrap: high bits are dropped deliberately.
  assign result      = shifted[out_SIZE-1:0];
  assign unused_high = ^shifted[ACC_W-1:out_SIZE];
`endif

endmodule

// File: rtl/fir_sequencer.sv
// FIR run sequencer: FSM, sample/tap counters, RAM/ROM address generation.
// Output scaling mode is selected by FIR_SAT_EN inside fir_mac.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int address_SIZE = ADDRESS_SIZE_DEF,
  parameter int data_SIZE    = DATA_SIZE_DEF,
  parameter int coef_SIZE    = COEF_SIZE_DEF,
  parameter int out_SIZE     = OUT_SIZE_DEF,
  parameter int TAPS         = TAPS_DEF,
  parameter int SHIFT        = SHIFT_DEF
) (
  input  logic                      a_clk,
  input  logic                      a_rst,
  input  logic                      start,
  input  logic [address_SIZE-1:0]   n_samples,
  output logic                      busy,
  output logic                      done,
  output logic [address_SIZE-1:0]   s_address,
  output logic                      s_rd,
  input  logic [data_SIZE-1:0]      s_data,
  output logic [$clog2(TAPS)-1:0]   c_address,
  input  logic [coef_SIZE-1:0]      c_data,
  output logic [address_SIZE-1:0]   o_address,
  output logic [out_SIZE-1:0]       o_data,
  output logic                      o_wr
);

  localparam int KW = $clog2(TAPS);

  state_t                  state_reg;
  state_t                  state_next;
  logic [address_SIZE-1:0] n_reg;
  logic [address_SIZE-1:0] count_reg;
  logic [KW-1:0]           k_reg;
  logic [address_SIZE-1:0] k_ext;
  logic                    valid_reg;
  logic                    accept;
  logic                    last_tap;
  logic                    last_sample;
  logic                    issue;
  logic [out_SIZE-1:0]     mac_result;

  assign k_ext       = {{(address_SIZE-KW){1'b0}}, k_reg};
  assign accept      = (state_reg == IDLE) && start;
  assign last_tap    = (k_reg == KW'(TAPS-1));
  assign last_sample = (n_reg == count_reg - 1'b1);
  // Taps reaching before x[0] are skipped: no read, no contribution.
  assign issue       = (state_reg == RUN) && (k_ext <= n_reg);

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (n_samples != '0) ? RUN : DONE;
      RUN:     if (last_tap) state_next = DRAIN;
      DRAIN:   state_next = WRITE;
      WRITE:   state_next = last_sample ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      n_reg     <= '0;
      count_reg <= '0;
      k_reg     <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= issue;
      case (state_reg)
        IDLE: begin
          if (start) begin
            n_reg     <= '0;
            k_reg     <= '0;
            count_reg <= n_samples;
          end
        end
        RUN:   k_reg <= k_reg + 1'b1;
        WRITE: begin
          k_reg <= '0;
          if (!last_sample) n_reg <= n_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  fir_mac #(
    .data_SIZE (data_SIZE),
    .coef_SIZE (coef_SIZE),
    .out_SIZE  (out_SIZE),
    .TAPS      (TAPS),
    .SHIFT     (SHIFT)
  ) u_mac (
    .clk    (a_clk),
    .srst   (a_rst),
    .clear  (accept || (state_reg == WRITE)),
    .enable (valid_reg),
    .sample (s_data),
    .coef   (c_data),
    .result (mac_result)
  );

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign s_rd      = issue;
  assign s_address = issue ? (n_reg - k_ext) : '0;
  assign c_address = (state_reg == RUN) ? k_reg : '0;
  assign o_wr      = (state_reg == WRITE);
  assign o_address = o_wr ? n_reg : '0;
  assign o_data    = o_wr ? mac_result : '0;

endmodule
